// File: rtl/overlay_box_ctrl.sv
// overlay_box_ctrl: owns the centre of the overlay marker box.
//   Tracker centres (valid/ready) and manual nudges are arbitrated into a
//   clamped pending centre. At frame start the pending centre is copied to a
//   shadow copy (COMMIT). The box edges are then driven from the shadow copy
//   (PUBLISH), so a frame never shows a box that is only partly moved.
// Ports:
//   PClk, Rst          pixel clock, synchronous active-high reset
//   VtcHCnt, VtcVCnt   timing-controller counters, used to detect frame start
//   mode_auto          1 = tracker drives the box, 0 = manual nudges only
//   trk_valid/ready    tracker centre handshake; trk_h/trk_v carry the centre
//   man_nudge          one-cycle pulses {up,down,left,right}
//   man_ack            one-cycle pulse on the cycle after a nudge is taken
//   box_*_lo/hi        committed box edges; box_upd pulses when they change
//   trk_lost           no tracker update for LOST_FRAMES frames
module overlay_box_ctrl #(
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned HALF        = 16,
  parameter int unsigned STEP        = 4,
  parameter int unsigned LOST_FRAMES = 8,
  parameter int unsigned DEF_H       = 160,
  parameter int unsigned DEF_V       = 120
) (
  input  logic        PClk,
  input  logic        Rst,
  input  logic [11:0] VtcHCnt,
  input  logic [10:0] VtcVCnt,
  input  logic        mode_auto,
  input  logic        trk_valid,
  input  logic [11:0] trk_h,
  input  logic [10:0] trk_v,
  output logic        trk_ready,
  input  logic [3:0]  man_nudge,
  output logic        man_ack,
  output logic [11:0] box_h_lo,
  output logic [11:0] box_h_hi,
  output logic [10:0] box_v_lo,
  output logic [10:0] box_v_hi,
  output logic        box_upd,
  output logic        trk_lost
);

  localparam int unsigned HW  = 12;
  localparam int unsigned VW  = 11;
  localparam int unsigned HSW = HW + 1;
  localparam int unsigned VSW = VW + 1;
  localparam int unsigned LCW = $clog2(LOST_FRAMES + 1);

  localparam logic [1:0] ST_ACTIVE  = 2'd0;
  localparam logic [1:0] ST_COMMIT  = 2'd1;
  localparam logic [1:0] ST_PUBLISH = 2'd2;

  localparam logic signed [HSW-1:0] H_MIN  = HSW'(HALF);
  localparam logic signed [HSW-1:0] H_MAX  = HSW'(H_ACTIVE - 1 - HALF);
  localparam logic signed [VSW-1:0] V_MIN  = VSW'(HALF);
  localparam logic signed [VSW-1:0] V_MAX  = VSW'(V_ACTIVE - 1 - HALF);
  localparam logic signed [HSW-1:0] H_HALF = HSW'(HALF);
  localparam logic signed [VSW-1:0] V_HALF = VSW'(HALF);
  localparam logic signed [HSW-1:0] H_STEP = HSW'(STEP);
  localparam logic signed [VSW-1:0] V_STEP = VSW'(STEP);
  localparam logic [LCW-1:0]        LOST_MAX = LCW'(LOST_FRAMES);

  // Saturate a signed coordinate into the range that keeps the box on screen.
  function automatic logic signed [HSW-1:0] clamp_h(input logic signed [HSW-1:0] x);
    if (x < H_MIN)      clamp_h = H_MIN;
    else if (x > H_MAX) clamp_h = H_MAX;
    else                clamp_h = x;
  endfunction

  function automatic logic signed [VSW-1:0] clamp_v(input logic signed [VSW-1:0] x);
    if (x < V_MIN)      clamp_v = V_MIN;
    else if (x > V_MAX) clamp_v = V_MAX;
    else                clamp_v = x;
  endfunction

  logic [1:0]            state_q, state_d;
  logic signed [HSW-1:0] pend_h_q, pend_h_d, sh_h_q, sh_h_d;
  logic signed [VSW-1:0] pend_v_q, pend_v_d, sh_v_q, sh_v_d;
  logic [HW-1:0]         box_h_lo_q, box_h_lo_d, box_h_hi_q, box_h_hi_d;
  logic [VW-1:0]         box_v_lo_q, box_v_lo_d, box_v_hi_q, box_v_hi_d;
  logic                  box_upd_q, box_upd_d;
  logic                  trk_ready_q, trk_ready_d;
  logic                  man_ack_q, man_ack_d;
  logic                  trk_lost_q, trk_lost_d;
  logic [LCW-1:0]        lost_cnt_q, lost_cnt_d;

  logic                  frame_start;
  logic                  trk_acc;
  logic                  auto_trk;
  logic                  nudge_take;
  logic signed [HSW-1:0] base_h, dh;
  logic signed [VSW-1:0] base_v, dv;

  // Next-state, arbitration, clamping and lost-tracker bookkeeping.
  always_comb begin
    state_d    = state_q;
    pend_h_d   = pend_h_q;
    pend_v_d   = pend_v_q;
    sh_h_d     = sh_h_q;
    sh_v_d     = sh_v_q;
    box_h_lo_d = box_h_lo_q;
    box_h_hi_d = box_h_hi_q;
    box_v_lo_d = box_v_lo_q;
    box_v_hi_d = box_v_hi_q;
    box_upd_d  = 1'b0;
    man_ack_d  = 1'b0;
    lost_cnt_d = lost_cnt_q;
    base_h     = pend_h_q;
    base_v     = pend_v_q;
    dh         = '0;
    dv         = '0;

    frame_start = (VtcHCnt == '0) && (VtcVCnt == VW'(V_ACTIVE));
    // trk_ready_q is high exactly while the FSM is in ACTIVE.
    trk_acc     = trk_valid && trk_ready_q;
    auto_trk    = mode_auto && !trk_lost_q;
    nudge_take  = trk_ready_q && (man_nudge != 4'b0000) && !auto_trk;

    case (state_q)
      ST_ACTIVE: begin
        if (frame_start) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        sh_h_d  = pend_h_q;
        sh_v_d  = pend_v_q;
        state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        box_h_lo_d = HW'(sh_h_q - H_HALF);
        box_h_hi_d = HW'(sh_h_q + H_HALF);
        box_v_lo_d = VW'(sh_v_q - V_HALF);
        box_v_hi_d = VW'(sh_v_q + V_HALF);
        box_upd_d  = 1'b1;
        state_d    = ST_ACTIVE;
      end
      default: state_d = ST_ACTIVE;
    endcase

    // Tracker value is clamped first so a nudge on top starts from a legal centre.
    if (trk_acc && mode_auto) begin
      base_h = clamp_h($signed({1'b0, trk_h}));
      base_v = clamp_v($signed({1'b0, trk_v}));
    end

    // {up,down,left,right}; opposing bits cancel.
    if (nudge_take) begin
      if (man_nudge[0]) dh = dh + H_STEP;
      if (man_nudge[1]) dh = dh - H_STEP;
      if (man_nudge[2]) dv = dv + V_STEP;
      if (man_nudge[3]) dv = dv - V_STEP;
    end

    pend_h_d  = clamp_h(base_h + dh);
    pend_v_d  = clamp_v(base_v + dv);
    man_ack_d = nudge_take;

    if (trk_acc && mode_auto) lost_cnt_d = '0;
    else if (frame_start && (lost_cnt_q != LOST_MAX)) lost_cnt_d = lost_cnt_q + LCW'(1);

    trk_ready_d = (state_d == ST_ACTIVE);
    trk_lost_d  = (lost_cnt_d == LOST_MAX);
  end

  // State and output registers.
  always_ff @(posedge PClk) begin
    if (Rst) begin
      state_q     <= ST_ACTIVE;
      pend_h_q    <= HSW'(DEF_H);
      pend_v_q    <= VSW'(DEF_V);
      sh_h_q      <= HSW'(DEF_H);
      sh_v_q      <= VSW'(DEF_V);
      box_h_lo_q  <= HW'(DEF_H - HALF);
      box_h_hi_q  <= HW'(DEF_H + HALF);
      box_v_lo_q  <= VW'(DEF_V - HALF);
      box_v_hi_q  <= VW'(DEF_V + HALF);
      box_upd_q   <= 1'b0;
      trk_ready_q <= 1'b1;
      man_ack_q   <= 1'b0;
      trk_lost_q  <= 1'b0;
      lost_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_h_q    <= pend_h_d;
      pend_v_q    <= pend_v_d;
      sh_h_q      <= sh_h_d;
      sh_v_q      <= sh_v_d;
      box_h_lo_q  <= box_h_lo_d;
      box_h_hi_q  <= box_h_hi_d;
      box_v_lo_q  <= box_v_lo_d;
      box_v_hi_q  <= box_v_hi_d;
      box_upd_q   <= box_upd_d;
      trk_ready_q <= trk_ready_d;
      man_ack_q   <= man_ack_d;
      trk_lost_q  <= trk_lost_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  assign trk_ready = trk_ready_q;
  assign man_ack   = man_ack_q;
  assign box_h_lo  = box_h_lo_q;
  assign box_h_hi  = box_h_hi_q;
  assign box_v_lo  = box_v_lo_q;
  assign box_v_hi  = box_v_hi_q;
  assign box_upd   = box_upd_q;
  assign trk_lost  = trk_lost_q;

endmodule

// File: tb/tb_overlay_box_ctrl.sv
// tb_overlay_box_ctrl: directed and randomized stimulus for overlay_box_ctrl,
// checked every cycle against a timeline/arithmetic reference model plus
// hand-computed constants at the key scenario points.
module tb_overlay_box_ctrl;

  localparam int H_ACTIVE = 320;
  localparam int V_ACTIVE = 240;
  localparam int HALF     = 16;
  localparam int STEP     = 4;
  localparam int LOSTN    = 8;
  localparam int DEF_H    = 160;
  localparam int DEF_V    = 120;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hcnt;
  logic [10:0] vcnt;
  logic        mode_auto;
  logic        trk_valid;
  logic [11:0] trk_h;
  logic [10:0] trk_v;
  logic        trk_ready;
  logic [3:0]  man_nudge;
  logic        man_ack;
  logic [11:0] box_h_lo, box_h_hi;
  logic [10:0] box_v_lo, box_v_hi;
  logic        box_upd;
  logic        trk_lost;

  int errors = 0;
  int checks = 0;
  int upd_seen = 0;

  // Reference model: pending/snapshot centres, visible edges, frame timeline.
  int m_ph, m_pv, m_sh, m_sv;
  int m_hlo, m_hhi, m_vlo, m_vhi;
  int m_lost;
  int m_age;
  bit m_ack, m_upd;

  overlay_box_ctrl dut (
    .PClk(clk), .Rst(rst), .VtcHCnt(hcnt), .VtcVCnt(vcnt),
    .mode_auto(mode_auto), .trk_valid(trk_valid), .trk_h(trk_h), .trk_v(trk_v),
    .trk_ready(trk_ready), .man_nudge(man_nudge), .man_ack(man_ack),
    .box_h_lo(box_h_lo), .box_h_hi(box_h_hi), .box_v_lo(box_v_lo), .box_v_hi(box_v_hi),
    .box_upd(box_upd), .trk_lost(trk_lost)
  );

  always #5 clk = ~clk;

  function automatic int clampi(input int x, input int lo, input int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = DEF_H; m_pv = DEF_V; m_sh = DEF_H; m_sv = DEF_V;
    m_hlo = DEF_H - HALF; m_hhi = DEF_H + HALF;
    m_vlo = DEF_V - HALF; m_vhi = DEF_V + HALF;
    m_lost = 0; m_age = 100; m_ack = 0; m_upd = 0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic cyc();
    bit fs, act, acc, take, auto_trk;
    int nh, nv;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      fs       = (hcnt == 0) && (vcnt == V_ACTIVE);
      act      = !(m_age == 1 || m_age == 2);
      acc      = act && trk_valid;
      auto_trk = mode_auto && (m_lost != LOSTN);
      take     = act && (man_nudge != 0) && !auto_trk;
      nh = m_ph; nv = m_pv;
      if (acc && mode_auto) begin
        nh = clampi(int'(trk_h), HALF, H_ACTIVE - 1 - HALF);
        nv = clampi(int'(trk_v), HALF, V_ACTIVE - 1 - HALF);
      end
      if (take) begin
        nh = clampi(nh + (man_nudge[0] ? STEP : 0) - (man_nudge[1] ? STEP : 0),
                    HALF, H_ACTIVE - 1 - HALF);
        nv = clampi(nv + (man_nudge[2] ? STEP : 0) - (man_nudge[3] ? STEP : 0),
                    HALF, V_ACTIVE - 1 - HALF);
      end
      if (m_age == 1) begin m_sh = m_ph; m_sv = m_pv; end
      m_upd = (m_age == 2);
      if (m_age == 2) begin
        m_hlo = m_sh - HALF; m_hhi = m_sh + HALF;
        m_vlo = m_sv - HALF; m_vhi = m_sv + HALF;
      end
      m_ack = take;
      m_ph = nh; m_pv = nv;
      if (acc && mode_auto) m_lost = 0;
      else if (fs && m_lost < LOSTN) m_lost = m_lost + 1;
      if (fs && act) m_age = 1;
      else if (m_age < 100) m_age = m_age + 1;
    end
    #1;
    if (box_upd === 1'b1) upd_seen++;
    chk("trk_ready", 32'(trk_ready), 32'(!(m_age == 1 || m_age == 2)));
    chk("man_ack",   32'(man_ack),   32'(m_ack));
    chk("box_upd",   32'(box_upd),   32'(m_upd));
    chk("trk_lost",  32'(trk_lost),  32'(m_lost == LOSTN));
    chk("box_h_lo",  32'(box_h_lo),  32'(m_hlo));
    chk("box_h_hi",  32'(box_h_hi),  32'(m_hhi));
    chk("box_v_lo",  32'(box_v_lo),  32'(m_vlo));
    chk("box_v_hi",  32'(box_v_hi),  32'(m_vhi));
  endtask

  // Non-frame-start timing values, including near misses of the decode.
  task automatic set_line();
    case ($urandom_range(0, 3))
      0: begin vcnt = 11'(V_ACTIVE); hcnt = 12'($urandom_range(1, 400)); end
      1: begin vcnt = 11'($urandom_range(V_ACTIVE + 1, 260)); hcnt = 12'd0; end
      default: begin vcnt = 11'($urandom_range(0, V_ACTIVE - 1)); hcnt = 12'($urandom_range(0, 400)); end
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_line(); trk_valid = 1'b0; man_nudge = 4'b0;
      cyc();
    end
  endtask

  task automatic fstart();
    hcnt = 12'd0; vcnt = 11'(V_ACTIVE); trk_valid = 1'b0; man_nudge = 4'b0;
    cyc();
    set_line();
  endtask

  // Frame start followed by COMMIT and PUBLISH, leaving new edges visible.
  task automatic frame_publish();
    fstart();
    idle(2);
  endtask

  task automatic chk_box(input string tag, input int hl, input int hh, input int vl, input int vh);
    chk({tag, "_hlo"}, 32'(box_h_lo), 32'(hl));
    chk({tag, "_hhi"}, 32'(box_h_hi), 32'(hh));
    chk({tag, "_vlo"}, 32'(box_v_lo), 32'(vl));
    chk({tag, "_vhi"}, 32'(box_v_hi), 32'(vh));
  endtask

  task automatic trk_send(input int h, input int v);
    set_line(); trk_valid = 1'b1; trk_h = 12'(h); trk_v = 11'(v); man_nudge = 4'b0;
    cyc();
    trk_valid = 1'b0;
  endtask

  task automatic nudge(input logic [3:0] n);
    set_line(); trk_valid = 1'b0; man_nudge = n;
    cyc();
    man_nudge = 4'b0;
  endtask

  initial begin
    int vp, np;
    model_reset();
    rst = 1'b1; hcnt = '0; vcnt = '0; mode_auto = 1'b1;
    trk_valid = 1'b0; trk_h = '0; trk_v = '0; man_nudge = '0;

    // Reset values.
    cyc(); cyc();
    rst = 1'b0;
    chk_box("reset", 144, 176, 104, 136);
    chk("reset_ready", 32'(trk_ready), 32'd1);
    chk("reset_upd", 32'(box_upd), 32'd0);
    chk("reset_lost", 32'(trk_lost), 32'd0);

    // Two idle frames: default box, one box_upd per frame.
    for (int f = 0; f < 2; f++) begin
      upd_seen = 0;
      idle(10); frame_publish(); idle(3);
      chk("idle_upd_count", 32'(upd_seen), 32'd1);
      chk_box("idle", 144, 176, 104, 136);
    end

    // Auto tracker centre: edges hold until publish.
    idle(3); trk_send(200, 50); idle(5);
    chk_box("trk_pre", 144, 176, 104, 136);
    fstart(); chk_box("trk_fs", 144, 176, 104, 136);
    cyc();    chk_box("trk_commit", 144, 176, 104, 136);
    cyc();    chk_box("trk_pub", 184, 216, 34, 66);
    chk("trk_pub_upd", 32'(box_upd), 32'd1);

    // Clamped tracker centre.
    idle(4); trk_send(5, 239); idle(3); frame_publish();
    chk_box("clamp", 0, 32, 207, 239);

    // Tracker goes stale, nudge is then honoured, tracker accept clears stale flag.
    for (int f = 0; f < 8; f++) begin idle(6); frame_publish(); end
    chk("lost_set", 32'(trk_lost), 32'd1);
    nudge(4'b0001);
    chk("lost_ack", 32'(man_ack), 32'd1);
    idle(2); frame_publish();
    chk("lost_nudge_hlo", 32'(box_h_lo), 32'd4);
    chk("lost_nudge_hhi", 32'(box_h_hi), 32'd36);
    trk_send(100, 100);
    chk("lost_clear", 32'(trk_lost), 32'd0);
    nudge(4'b0010);
    chk("auto_nudge_drop", 32'(man_ack), 32'd0);

    // Manual mode: tracker ignored, left nudges saturate at the edge.
    trk_send(20, 120); idle(2);
    mode_auto = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_line(); trk_valid = 1'b1; trk_h = 12'd300; trk_v = 11'd200; man_nudge = 4'b0010;
      cyc();
      chk("man_ack", 32'(man_ack), 32'd1);
      idle(1);
    end
    frame_publish();
    chk_box("man_sat", 0, 32, 104, 136);

    // Nudge during COMMIT is dropped without ack.
    idle(3); fstart();
    nudge(4'b0001);
    chk("commit_noack", 32'(man_ack), 32'd0);
    cyc(); idle(1);
    chk("commit_noack2", 32'(man_ack), 32'd0);
    chk("commit_hlo", 32'(box_h_lo), 32'd0);
    idle(2); frame_publish();
    chk("commit_hlo2", 32'(box_h_lo), 32'd0);

    // Reset during PUBLISH: default box, no update pulse.
    nudge(4'b0001); nudge(4'b0001); idle(2);
    fstart(); cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk_box("rst_pub", 144, 176, 104, 136);
    chk("rst_pub_upd", 32'(box_upd), 32'd0);
    idle(3); frame_publish();
    chk_box("rst_pub2", 144, 176, 104, 136);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      mode_auto = 1'($urandom_range(0, 1));
      vp = $urandom_range(0, 2);
      np = $urandom_range(0, 3);
      for (int c = 0; c < 40; c++) begin
        if (c == 30) begin hcnt = 12'd0; vcnt = 11'(V_ACTIVE); end
        else set_line();
        rst = ($urandom_range(0, 499) == 0);
        if (vp != 0 && $urandom_range(0, 3) < vp) begin
          trk_valid = 1'b1;
          case ($urandom_range(0, 3))
            0: begin trk_h = 12'd0; trk_v = 11'(V_ACTIVE - 1); end
            1: begin trk_h = 12'(H_ACTIVE - 1); trk_v = 11'd0; end
            default: begin
              trk_h = 12'($urandom_range(0, H_ACTIVE - 1));
              trk_v = 11'($urandom_range(0, V_ACTIVE - 1));
            end
          endcase
        end else trk_valid = 1'b0;
        man_nudge = ($urandom_range(0, 3) < np) ? 4'($urandom_range(1, 15)) : 4'b0;
        cyc();
      end
      rst = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
